el2_dccm_port_arb: RTL



---
 rtl/el2_dccm_port_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/el2_dccm_port_arb.sv
// ---------------------------------------------------------------------------
// el2_dccm_port_arb
//
// Arbitrates one single-ported DCCM between the LSU and a DMA master.
// LSU normally wins. A DMA request that keeps losing is promoted to
// priority after STARVE_MAX consecutive lost cycles. Priority returns to
// the LSU once the DMA is served or withdraws its request.
//
// Handshake: a request is consumed in the same cycle its grant is 1.
// There is no holding register. A requester that is not granted keeps its
// request asserted and retries. Read data returns exactly one cycle after
// the grant, tagged by lsu_rvalid or dma_rvalid.
//
// Ports
//   clk, rst_l                    clock, asynchronous active-low reset
//   lsu_req/wr/addr/wdata         LSU access request
//   dma_req/wr/addr/wdata         DMA access request
//   lsu_gnt, dma_gnt              same-cycle grants
//   dccm_rden/wren/addr/wdata     DCCM port drive
//   dccm_rdata                    DCCM read data, one cycle after rden
//   lsu_rvalid, dma_rvalid        read-return strobes
//   rd_data                       read data (dccm_rdata passed through)
//   dma_promoted                  arbiter state: 1 while DMA has priority
// ---------------------------------------------------------------------------
module el2_dccm_port_arb #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int STARVE_MAX       = 3
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        lsu_req,
    input  logic                        lsu_wr,
    input  logic [DCCM_BITS-1:0]        lsu_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata,
    input  logic                        dma_req,
    input  logic                        dma_wr,
    input  logic [DCCM_BITS-1:0]        dma_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
    output logic                        lsu_gnt,
    output logic                        dma_gnt,
    output logic                        dccm_rden,
    output logic                        dccm_wren,
    output logic [DCCM_BITS-1:0]        dccm_addr,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wdata,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rdata,
    output logic                        lsu_rvalid,
    output logic                        dma_rvalid,
    output logic [DCCM_FDATA_WIDTH-1:0] rd_data,
    output logic                        dma_promoted
);

    localparam logic LSU_PRI = 1'b0;
    localparam logic DMA_PRI = 1'b1;

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    logic       state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [3:0] starve_inc;
    logic [1:0] owner_q, owner_d;   // {lsu read, dma read} granted last cycle
    logic       dma_lost;

    // Grants depend only on the registered state. Because of this, a
    // transition at the coming edge cannot affect this cycle's winner.
    always_comb begin
        lsu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (state_q == LSU_PRI) begin
            lsu_gnt = lsu_req;
            dma_gnt = dma_req & ~lsu_req;
        end else begin
            dma_gnt = dma_req;
            lsu_gnt = lsu_req & ~dma_req;
        end
    end

    // DCCM port mux. When there is no grant, the mux drives zeros so that
    // the port never shows stale values.
    always_comb begin
        dccm_rden  = 1'b0;
        dccm_wren  = 1'b0;
        dccm_addr  = '0;
        dccm_wdata = '0;
        if (lsu_gnt) begin
            dccm_rden  = ~lsu_wr;
            dccm_wren  = lsu_wr;
            dccm_addr  = lsu_addr;
            dccm_wdata = lsu_wdata;
        end else if (dma_gnt) begin
            dccm_rden  = ~dma_wr;
            dccm_wren  = dma_wr;
            dccm_addr  = dma_addr;
            dccm_wdata = dma_wdata;
        end
    end

    // Starvation tracking and the priority state machine.
    always_comb begin
        dma_lost     = dma_req & ~dma_gnt;
        starve_inc   = starve_cnt_q + 4'd1;
        starve_cnt_d = 4'd0;
        if (dma_lost) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX_C) ? starve_cnt_q : starve_inc;
        end

        state_d = state_q;
        if (state_q == LSU_PRI) begin
            // Promote at the edge where this loss brings the count to the limit.
            if (dma_lost && (starve_inc == STARVE_MAX_C)) begin
                state_d = DMA_PRI;
            end
        end else begin
            // Priority lasts until the DMA is served or it withdraws.
            if (dma_gnt || !dma_req) begin
                state_d = LSU_PRI;
            end
        end

        owner_d = {lsu_gnt & ~lsu_wr, dma_gnt & ~dma_wr};
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= LSU_PRI;
            starve_cnt_q <= 4'd0;
            owner_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end

    assign lsu_rvalid   = owner_q[1];
    assign dma_rvalid   = owner_q[0];
    assign rd_data      = dccm_rdata;
    assign dma_promoted = (state_q == DMA_PRI);

endmodule
